// File: rtl/rr_mux_nx1.sv
// ============================================================================
//  Module   : rr_mux_nx1
//  Purpose  : N-to-1 valid/ready stream mux with a registered output stage.
//             It supports fixed-select and round-robin modes.
//             Define RR_MUX_BURST_EN to lock round-robin grants into bursts
//             of up to BURST_LEN beats.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_mux_nx1 #(
  parameter int NUM_CH    = 4,
  parameter int DATA_W    = 8,
`ifdef RR_MUX_BURST_EN
  parameter int BURST_LEN = 4,
`endif
  parameter int SEL_W     = $clog2(NUM_CH)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_CH*DATA_W-1:0] in_data,
  input  logic [NUM_CH-1:0]        in_valid,
  output logic [NUM_CH-1:0]        in_ready,
  input  logic                     mode,
  input  logic [SEL_W-1:0]         sel,
  output logic [DATA_W-1:0]        out_data,
  output logic [SEL_W-1:0]         out_ch,
  output logic                     out_valid,
  input  logic                     out_ready
);

  localparam logic [SEL_W:0]   NUM_CH_X = (SEL_W+1)'(NUM_CH);
  localparam logic [SEL_W-1:0] LAST_CH  = SEL_W'(NUM_CH - 1);

  logic                out_valid_q, out_valid_d;
  logic [DATA_W-1:0]   out_data_q,  out_data_d;
  logic [SEL_W-1:0]    out_ch_q,    out_ch_d;
  logic [SEL_W-1:0]    ptr_q,       ptr_d;

  logic                load;
  logic [NUM_CH-1:0]   fix_grant;
  logic [NUM_CH-1:0]   rr_grant;
  logic                rr_found;
  logic [SEL_W:0]      rr_idx;
  logic [NUM_CH-1:0]   grant;
  logic [NUM_CH-1:0]   xfer;
  logic                xfer_any;
  logic [SEL_W-1:0]    xfer_ch;
  logic [DATA_W-1:0]   xfer_data;
  logic [SEL_W-1:0]    ptr_next;
  logic [DATA_W-1:0]   ch_data [NUM_CH];

  // A new beat may enter whenever the output slot is empty or being drained.
  assign load = !out_valid_q || out_ready;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    assign ch_data[i] = in_data[i*DATA_W +: DATA_W];
  end

  always_comb begin
    fix_grant = '0;
    if ({1'b0, sel} < NUM_CH_X) begin
      fix_grant[sel] = in_valid[sel];
    end
  end

  // Circular search starting at the pointer; the first valid channel wins.
  always_comb begin
    rr_grant = '0;
    rr_found = 1'b0;
    rr_idx   = '0;
    for (int j = 0; j < NUM_CH; j++) begin
      rr_idx = {1'b0, ptr_q} + (SEL_W+1)'(j);
      if (rr_idx >= NUM_CH_X) begin
        rr_idx = rr_idx - NUM_CH_X;
      end
      if (!rr_found && in_valid[rr_idx[SEL_W-1:0]]) begin
        rr_grant[rr_idx[SEL_W-1:0]] = 1'b1;
        rr_found                    = 1'b1;
      end
    end
  end

`ifdef RR_MUX_BURST_EN
  localparam int                CNT_W     = $clog2(BURST_LEN + 1);
  localparam logic [CNT_W-1:0] BURST_MAX = CNT_W'(BURST_LEN);

  logic               lock_q,    lock_d;
  logic [SEL_W-1:0]   lock_ch_q, lock_ch_d;
  logic [CNT_W-1:0]   cnt_q,     cnt_d;
  logic [CNT_W-1:0]   cnt_inc;
  logic               lock_hold;

  assign lock_hold = mode && lock_q && in_valid[lock_ch_q];

  always_comb begin
    if (!mode) begin
      grant = fix_grant;
    end else if (lock_hold) begin
      grant = NUM_CH'(1) << lock_ch_q;
    end else begin
      grant = rr_grant;
    end
  end

  // The pointer already sits past the locked channel, so a release falls back to it.
  always_comb begin
    lock_d    = lock_q;
    lock_ch_d = lock_ch_q;
    cnt_d     = cnt_q;
    cnt_inc   = lock_hold ? cnt_q + 1'b1 : CNT_W'(1);
    if (!mode || (lock_q && !in_valid[lock_ch_q])) begin
      lock_d = 1'b0;
      cnt_d  = '0;
    end
    if (mode && xfer_any) begin
      if (cnt_inc == BURST_MAX) begin
        lock_d = 1'b0;
        cnt_d  = '0;
      end else begin
        lock_d    = 1'b1;
        lock_ch_d = xfer_ch;
        cnt_d     = cnt_inc;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lock_q    <= 1'b0;
      lock_ch_q <= '0;
      cnt_q     <= '0;
    end else begin
      lock_q    <= lock_d;
      lock_ch_q <= lock_ch_d;
      cnt_q     <= cnt_d;
    end
  end
`else
  always_comb begin
    grant = mode ? rr_grant : fix_grant;
  end
`endif

  assign in_ready = grant & {NUM_CH{load && !rst}};
  assign xfer     = in_valid & in_ready;
  assign xfer_any = |xfer;

  always_comb begin
    xfer_ch   = '0;
    xfer_data = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (grant[i]) begin
        xfer_ch   = SEL_W'(i);
        xfer_data = ch_data[i];
      end
    end
  end

  assign ptr_next = (xfer_ch == LAST_CH) ? '0 : xfer_ch + 1'b1;

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_ch_d    = out_ch_q;
    ptr_d       = ptr_q;
    if (xfer_any) begin
      out_valid_d = 1'b1;
      out_data_d  = xfer_data;
      out_ch_d    = xfer_ch;
      if (mode) begin
        ptr_d = ptr_next;
      end
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ch_q    <= '0;
      ptr_q       <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_ch_q    <= out_ch_d;
      ptr_q       <= ptr_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_ch    = out_ch_q;

endmodule

`default_nettype wire

// File: tb/tb_rr_mux_nx1.sv
// ============================================================================
//  Module   : tb_rr_mux_nx1
//  Purpose  : Self-checking bench for rr_mux_nx1 (default build, 4 x 8-bit).
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rr_mux_nx1;

  localparam int NUM_CH = 4;
  localparam int DATA_W = 8;
  localparam int SEL_W  = 2;

  logic                     clk = 1'b0;
  logic                     rst;
  logic [NUM_CH*DATA_W-1:0] in_data;
  logic [NUM_CH-1:0]        in_valid;
  logic [NUM_CH-1:0]        in_ready;
  logic                     mode;
  logic [SEL_W-1:0]         sel;
  logic [DATA_W-1:0]        out_data;
  logic [SEL_W-1:0]         out_ch;
  logic                     out_valid;
  logic                     out_ready;

  always #5 clk = ~clk;

  rr_mux_nx1 #(
    .NUM_CH (NUM_CH),
    .DATA_W (DATA_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .mode      (mode),
    .sel       (sel),
    .out_data  (out_data),
    .out_ch    (out_ch),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference state: the beat held at the output and the round-robin start point.
  bit               m_valid = 1'b0;
  logic [DATA_W-1:0] m_data = '0;
  int               m_ch    = 0;
  int               m_ptr   = 0;
  int               last_grant = -1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int pick_channel();
    int c;
    if (!mode) begin
      if (int'(sel) < NUM_CH && in_valid[sel]) return int'(sel);
      return -1;
    end
    for (int j = 0; j < NUM_CH; j++) begin
      c = (m_ptr + j) % NUM_CH;
      if (in_valid[c]) return c;
    end
    return -1;
  endfunction

  // One clock cycle: inputs are already driven; ready is checked before the edge
  // and the registered outputs after it.
  task automatic step();
    int               g;
    bit               ld;
    logic [NUM_CH-1:0] exp_rdy;
    #1;
    ld      = !m_valid || out_ready;
    g       = pick_channel();
    exp_rdy = '0;
    if (g >= 0 && ld && !rst) exp_rdy[g] = 1'b1;
    check("in_ready", 32'(in_ready), 32'(exp_rdy));
    @(posedge clk);
    last_grant = -1;
    if (rst) begin
      m_valid = 1'b0;
      m_data  = '0;
      m_ch    = 0;
      m_ptr   = 0;
    end else if (exp_rdy != '0) begin
      m_valid    = 1'b1;
      m_data     = in_data[g*DATA_W +: DATA_W];
      m_ch       = g;
      last_grant = g;
      if (mode) m_ptr = (g + 1) % NUM_CH;
    end else if (out_ready) begin
      m_valid = 1'b0;
    end
    @(negedge clk);
    check("out_valid", 32'(out_valid), 32'(m_valid));
    check("out_data",  32'(out_data),  32'(m_data));
    check("out_ch",    32'(out_ch),    32'(m_ch));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst       = 1'b1;
    in_valid  = '1;
    in_data   = 32'h44_33_22_11;
    mode      = 1'b1;
    sel       = '0;
    out_ready = 1'b1;

    // Reset held two cycles with every channel requesting.
    repeat (2) begin
      step();
      check("rst_out_valid", 32'(out_valid), 32'd0);
    end
    rst = 1'b0;

    // Fixed select of channel 2.
    mode    = 1'b0;
    sel     = 2'd2;
    in_data = 32'h44_A5_22_11;
    repeat (4) begin
      step();
      check("fix_data", 32'(out_data), 32'hA5);
      check("fix_ch",   32'(out_ch),   32'd2);
    end

    // Round-robin fairness with all channels valid.
    mode = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      check("rr_seq", 32'(out_ch), 32'(i % NUM_CH));
    end

    // Backpressure: load 3C from ch0, stall three cycles, then release.
    in_data = 32'h44_33_22_3C;
    step();
    check("bp_load", 32'(out_data), 32'h3C);
    out_ready = 1'b0;
    repeat (3) begin
      step();
      check("bp_hold", 32'(out_data), 32'h3C);
    end
    out_ready = 1'b1;
    step();
    check("bp_next", 32'(out_ch), 32'd1);

    // Sparse round-robin from pointer 2: expect 3, 1, 3.
    in_valid = 4'b1010;
    step();
    check("sparse0", 32'(out_ch), 32'd3);
    step();
    check("sparse1", 32'(out_ch), 32'd1);
    step();
    check("sparse2", 32'(out_ch), 32'd3);

    // Fixed select of an idle channel: output drains and stays empty.
    mode     = 1'b0;
    sel      = 2'd3;
    in_valid = 4'b0010;
    repeat (2) step();
    check("idle_sel", 32'(out_valid), 32'd0);

    // Randomised traffic; producers hold data and valid until accepted.
    for (int cyc = 0; cyc < 400; cyc++) begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (last_grant == c || !in_valid[c]) begin
          in_valid[c]                 = ($urandom_range(0, 2) != 0);
          in_data[c*DATA_W +: DATA_W] = DATA_W'($urandom);
        end
      end
      if (rst) rst = 1'b0;
      else     rst = ($urandom_range(0, 99) == 0);
      out_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 15) == 0) mode = ~mode;
      if ($urandom_range(0, 7) == 0)  sel  = SEL_W'($urandom);
      step();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/rr_mux_nx1.md
Name: rr_mux_nx1

Overview:
- Parametrised N-to-1 data multiplexer with per-channel valid/ready handshakes and a registered output stage.
- Successor to the combinational 4x1 mux. Adds generic width and channel count, two selection modes (fixed select or round-robin arbitration), backpressure, and a reported source channel.
- Sits between multiple producer streams and a single consumer in the verification sandbox datapaths.

Parameters:
- NUM_CH, 4, number of input channels (must be >= 2).
- DATA_W, 8, width of each channel's data.
- SEL_W, $clog2(NUM_CH), width of channel index (derived; do not override).

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- in_data  input  NUM_CH*DATA_W  packed channel data; channel i at bits [i*DATA_W +: DATA_W].
- in_valid  input  NUM_CH  per-channel valid.
- in_ready  output  NUM_CH  per-channel ready.
- mode  input  1  0 = fixed select, 1 = round-robin.
- sel  input  SEL_W  channel chosen in fixed mode; values >= NUM_CH select nothing.
- out_data  output  DATA_W  registered output data.
- out_ch  output  SEL_W  index of the channel that supplied out_data.
- out_valid  output  1  output holds a beat.
- out_ready  input  1  consumer accepts the beat.

Behaviour:
- Reset (rst=1 at a clk edge):
  - out_valid=0, out_data=0, out_ch=0.
  - RR pointer = 0; in_ready = all zeros during reset.
- Load enable: load = !out_valid || out_ready. The output register accepts a new beat only when load=1.
- Grant, computed combinationally each cycle (one-hot, at most one bit set):
  - Fixed mode: grant[sel] = in_valid[sel], if sel < NUM_CH; otherwise grant = 0.
  - Round-robin mode: the first i with in_valid[i]=1, searching ptr, ptr+1, ..., NUM_CH-1, 0, ..., ptr-1 (wraps).
- in_ready[i] = grant[i] && load && !rst. A transfer on channel i happens when in_valid[i] && in_ready[i].
- On a transfer from channel k: out_data <= channel k data, out_ch <= k, out_valid <= 1.
- Output held: out_valid=1 && out_ready=0 → out_data, out_ch and out_valid stay stable. No in_ready is asserted.
- Output drained with no new transfer: out_valid=1 && out_ready=1 → out_valid <= 0.
- Simultaneous drain and fill in the same cycle: the new beat replaces the old one. This gives full throughput of 1 beat/cycle.
- RR pointer:
  - Updates only on a transfer in round-robin mode: ptr <= (k == NUM_CH-1) ? 0 : k+1.
  - Unchanged in fixed mode and on idle cycles.
- Latency: 1 cycle from an input handshake to out_valid.
- Mode or sel change: takes effect on the next grant evaluation. A beat already in the output register is unaffected.
- Reset mid-operation: any pending output beat is discarded; out_valid=0 on the next cycle.
- Inputs with in_valid=0 are never granted. Producers must hold data and valid stable until in_ready.

Optional Feature:
- Macro: RR_MUX_BURST_EN.
- Defined:
  - Adds parameter BURST_LEN (default 4) and a beat counter.
  - In round-robin mode, after a transfer from channel k, grant stays locked on k while in_valid[k]=1, for up to BURST_LEN consecutive transfers.
  - The lock releases early when in_valid[k]=0 is seen at grant time.
  - On release, ptr <= k+1 (wrapped) and the counter clears.
  - Stall cycles (load=0) do not count. Reset clears the lock.
- Not defined: strict per-beat round-robin as in Behaviour. No BURST_LEN parameter or counter logic.

Test Plan:
- Reset: assert rst 2 cycles with all in_valid=1 → out_valid=0, out_data=0, out_ch=0, in_ready=0000 throughout.
- Fixed mode, NUM_CH=4, DATA_W=8: mode=0, sel=2, in_data ch2=8'hA5, all in_valid=1, out_ready=1 → in_ready=0100; out_data=A5, out_ch=2 one cycle later, every cycle.
- Round-robin fairness: mode=1, all four channels valid continuously, out_ready=1 → out_ch sequence 0,1,2,3,0,1,... with one beat per cycle.
- Backpressure: out_valid=1 with out_data=8'h3C, out_ready=0 for 3 cycles → out_data/out_ch stable, in_ready=0000; then out_ready=1 → next granted beat appears the following cycle with no loss or duplication.
- Sparse RR: only ch1 and ch3 valid, ptr=2 → grant ch3 first, then ch1, then ch3. Fixed mode with sel=3 while in_valid[3]=0 → no transfer, out_valid falls after drain.
- RR_MUX_BURST_EN, BURST_LEN=4: all channels valid → out_ch 0,0,0,0,1,1,1,1,... Dropping in_valid[1] after 2 beats → the switch to ch2 happens on the next grant.
